// File: rtl/led_rle_serializer.sv
// WS2801 strip driver: captures a run-length colour table, scales it by a global brightness
// and shifts exactly LEDS 24-bit words per frame on dOut/clkOut, followed by a latch gap.
module led_rle_serializer #(
    parameter int LEDS     = 50,
    parameter int BIN_QTY  = 12,
    parameter int FREQ     = 12_500_000,
    parameter int FREQ_DIV = 4,
    parameter int LATCH_US = 500,
    localparam int CNT_W   = $clog2(LEDS + 1)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            frame_valid_i,
    output logic                            frame_ready_o,
    input  logic [BIN_QTY-1:0][23:0]        rgb_i,
    input  logic [BIN_QTY-1:0][CNT_W-1:0]   counts_i,
    input  logic [7:0]                      brightness_i,
    input  logic                            pad_mode_i,
    output logic                            dOut_o,
    output logic                            clkOut_o,
    output logic                            busy_o,
    output logic                            frame_done_o,
    output logic                            overflow_o
);

    // state | meaning
    // IDLE  | frame_ready high, waiting for a table
    // SCAN  | pick next non-empty bin (or pad) one bin per cycle
    // SHIFT | 24 bits MSB first, FREQ_DIV clk cycles per bit
    // LATCH | clkOut/dOut low for GAP_CYCLES, then IDLE
    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, LATCH} state_t;

    localparam longint GAP_L      = longint'(LATCH_US) * longint'(FREQ) / longint'(1_000_000);
    localparam int     GAP_CYCLES = int'(GAP_L);
    localparam int     GAP_W      = $clog2(GAP_CYCLES + 1);
    localparam int     BIN_W      = $clog2(BIN_QTY + 1);
    localparam int     IDX_W      = (BIN_QTY > 1) ? $clog2(BIN_QTY) : 1;
    localparam int     PH_W       = $clog2(FREQ_DIV);
    localparam int     SUM_W      = CNT_W + $clog2(BIN_QTY);

    state_t                        state_q;
    logic [GAP_W-1:0]              gap_q;
    logic [BIN_QTY-1:0][23:0]      rgb_q;
    logic [BIN_QTY-1:0][CNT_W-1:0] cnt_q;
    logic [7:0]                    bri_q;
    logic                          pad_q;
    logic [CNT_W-1:0]              words_q;
    logic [BIN_W-1:0]              bin_q;
    logic [IDX_W-1:0]              last_q;
    logic                          have_last_q;
    logic                          ovf_pend_q;
    logic [23:0]                   shreg_q;
    logic [4:0]                    bit_q;
    logic [PH_W-1:0]               phase_q;
    logic                          frame_ready_q;
    logic                          dOut_q;
    logic                          clkOut_q;
    logic                          busy_q;
    logic                          frame_done_q;
    logic                          overflow_q;

    logic [SUM_W-1:0]              sum_d;
    logic                          ovf_d;
    logic [IDX_W-1:0]              bin_idx;
    logic                          bin_live;
    logic [CNT_W-1:0]              cnt_cur;
    logic [23:0]                   word_d;

    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] p;
        p = {8'd0, c} * ({8'd0, b} + 16'd1);
        return p[15:8];
    endfunction

    function automatic logic [23:0] scale24(input logic [23:0] w, input logic [7:0] b);
        return {scale8(w[23:16], b), scale8(w[15:8], b), scale8(w[7:0], b)};
    endfunction

    // Overflow is decided from the table as captured; the sum is wide enough never to wrap.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < BIN_QTY; i++) begin
            sum_d = sum_d + SUM_W'(counts_i[i]);
        end
        ovf_d = (sum_d > SUM_W'(LEDS));
    end

    always_comb begin
        bin_idx  = bin_q[IDX_W-1:0];
        bin_live = (bin_q < BIN_W'(BIN_QTY));
        cnt_cur  = cnt_q[bin_idx];
        word_d   = 24'd0;
        if (bin_live) begin
            word_d = scale24(rgb_q[bin_idx], bri_q);
        end else if (pad_q && have_last_q) begin
            word_d = scale24(rgb_q[last_q], bri_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= LATCH;
            gap_q         <= '0;
            rgb_q         <= '0;
            cnt_q         <= '0;
            bri_q         <= '0;
            pad_q         <= 1'b0;
            words_q       <= '0;
            bin_q         <= '0;
            last_q        <= '0;
            have_last_q   <= 1'b0;
            ovf_pend_q    <= 1'b0;
            shreg_q       <= '0;
            bit_q         <= '0;
            phase_q       <= '0;
            frame_ready_q <= 1'b0;
            dOut_q        <= 1'b0;
            clkOut_q      <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (frame_valid_i && frame_ready_q) begin
                        rgb_q         <= rgb_i;
                        cnt_q         <= counts_i;
                        bri_q         <= brightness_i;
                        pad_q         <= pad_mode_i;
                        words_q       <= '0;
                        bin_q         <= '0;
                        have_last_q   <= 1'b0;
                        ovf_pend_q    <= ovf_d;
                        frame_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= SCAN;
                    end
                end
                SCAN: begin
                    dOut_q   <= 1'b0;
                    clkOut_q <= 1'b0;
                    if (words_q == CNT_W'(LEDS)) begin
                        frame_done_q <= 1'b1;
                        overflow_q   <= ovf_pend_q;
                        gap_q        <= '0;
                        state_q      <= LATCH;
                    end else if (bin_live && (cnt_cur == '0)) begin
                        bin_q <= bin_q + BIN_W'(1);
                    end else begin
                        // First bit is presented on the same edge that enters SHIFT.
                        if (bin_live) begin
                            cnt_q[bin_idx] <= cnt_cur - CNT_W'(1);
                            last_q         <= bin_idx;
                            have_last_q    <= 1'b1;
                        end
                        shreg_q <= word_d;
                        dOut_q  <= word_d[23];
                        bit_q   <= 5'd23;
                        phase_q <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (phase_q == PH_W'(FREQ_DIV - 1)) begin
                        phase_q  <= '0;
                        clkOut_q <= 1'b0;
                        if (bit_q == 5'd0) begin
                            words_q <= words_q + CNT_W'(1);
                            dOut_q  <= 1'b0;
                            state_q <= SCAN;
                        end else begin
                            bit_q   <= bit_q - 5'd1;
                            shreg_q <= {shreg_q[22:0], 1'b0};
                            dOut_q  <= shreg_q[22];
                        end
                    end else begin
                        phase_q  <= phase_q + PH_W'(1);
                        clkOut_q <= (phase_q >= PH_W'(FREQ_DIV / 2 - 1));
                    end
                end
                LATCH: begin
                    dOut_q   <= 1'b0;
                    clkOut_q <= 1'b0;
                    if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                        frame_ready_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= IDLE;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                default: begin
                    gap_q   <= '0;
                    state_q <= LATCH;
                end
            endcase
        end
    end

    assign frame_ready_o = frame_ready_q;
    assign dOut_o        = dOut_q;
    assign clkOut_o      = clkOut_q;
    assign busy_o        = busy_q;
    assign frame_done_o  = frame_done_q;
    assign overflow_o    = overflow_q;

endmodule
